// File: rtl/sseg_scan_if.sv
// Multiplexed seven-segment display bus: active-low anodes and segments CA..CG.
// The master drives the display, the slave (scan decoder) only observes it.
interface sseg_scan_if;
  logic [3:0] AN;
  logic       CA;
  logic       CB;
  logic       CC;
  logic       CD;
  logic       CE;
  logic       CF;
  logic       CG;

  modport master (output AN, CA, CB, CC, CD, CE, CF, CG);
  modport slave  (input  AN, CA, CB, CC, CD, CE, CF, CG);
endinterface

// File: rtl/sseg_scan_decoder.sv
// Loopback monitor for a multiplexed 4-digit seven-segment display: follows the anode
// scan, decodes each settled digit back to hex and publishes whole frames.
module sseg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic            clk,
  input  logic            rst,
  sseg_scan_if.slave      bus,
  output logic [3:0][3:0] digit_array,
  output logic [3:0]      blank_mask,
  output logic [13:0]     number,
  output logic            frame_valid,
  output logic            dec_error,
  output logic            an_error,
  output logic            stalled
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [10:0]   SNAP_IDLE  = 11'h7FF;

  // Result layout: {error, blank, digit[3:0]}; input is active-high gfedcba.
  function automatic logic [5:0] decode_seg(input logic [6:0] p);
    case (p)
      7'h3F: decode_seg = 6'h00;
      7'h06: decode_seg = 6'h01;
      7'h5B: decode_seg = 6'h02;
      7'h4F: decode_seg = 6'h03;
      7'h66: decode_seg = 6'h04;
      7'h6D: decode_seg = 6'h05;
      7'h7D: decode_seg = 6'h06;
      7'h07: decode_seg = 6'h07;
      7'h7F: decode_seg = 6'h08;
      7'h6F: decode_seg = 6'h09;
      7'h77: decode_seg = 6'h0A;
      7'h7C: decode_seg = 6'h0B;
      7'h39: decode_seg = 6'h0C;
      7'h5E: decode_seg = 6'h0D;
      7'h79: decode_seg = 6'h0E;
      7'h71: decode_seg = 6'h0F;
      7'h00: decode_seg = 6'h10;
      default: decode_seg = 6'h20;
    endcase
  endfunction

  logic [10:0]      snap_q, snap_d, prev_q, prev_d;
  logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
  logic             dwell_done_q, dwell_done_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic             cap_last_q, cap_last_d;
  logic [3:0]       seen_q, seen_d;
  logic [3:0][3:0]  slot_digit_q, slot_digit_d;
  logic [3:0]       slot_blank_q, slot_blank_d;
  logic [3:0]       slot_err_q, slot_err_d;
  logic [3:0][3:0]  digit_array_q, digit_array_d;
  logic [3:0]       blank_mask_q, blank_mask_d;
  logic [13:0]      number_q, number_d;
  logic             frame_valid_q, frame_valid_d;
  logic             dec_error_q, dec_error_d;
  logic             an_error_q, an_error_d;
  logic             stalled_q, stalled_d;

  logic [3:0]  an_low;
  logic [3:0]  digit_big;
  logic [2:0]  zero_cnt;
  logic [1:0]  cap_idx;
  logic        changed, settle_hit, capture, frame_go, frame_bad;
  logic [5:0]  dec;
  logic [13:0] num_calc;

  assign an_low = ~snap_q[10:7];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_big
      assign digit_big[gi] = (slot_digit_q[gi] > 4'd9);
    end
  endgenerate

  assign frame_bad = (|slot_err_q) | (|digit_big);
  assign num_calc  = 14'(slot_digit_q[3]) * 14'd1000 + 14'(slot_digit_q[2]) * 14'd100
                   + 14'(slot_digit_q[1]) * 14'd10 + 14'(slot_digit_q[0]);

  always_comb begin
    snap_d   = {bus.AN, bus.CG, bus.CF, bus.CE, bus.CD, bus.CC, bus.CB, bus.CA};
    prev_d   = snap_q;
    changed  = (snap_q != prev_q);
    zero_cnt = '0;
    cap_idx  = '0;
    for (int i = 0; i < 4; i++) begin
      zero_cnt = zero_cnt + {2'b00, an_low[i]};
      if (an_low[i]) cap_idx = 2'(i);
    end
    settle_hit = !changed && (settle_cnt_q == SETTLE_MAX) && !dwell_done_q;
    capture    = settle_hit && (zero_cnt == 3'd1);
    an_error_d = settle_hit && (zero_cnt > 3'd1);

    if (changed)                        settle_cnt_d = '0;
    else if (settle_cnt_q != SETTLE_MAX) settle_cnt_d = settle_cnt_q + 1'b1;
    else                                settle_cnt_d = settle_cnt_q;
    // Every settled dwell is consumed once, including blanking and multi-anode ones.
    dwell_done_d = changed ? 1'b0 : (dwell_done_q | settle_hit);

    dec        = decode_seg(~snap_q[6:0]);
    frame_go   = cap_last_q && (seen_q == 4'hF);
    cap_last_d = capture;

    seen_d        = seen_q;
    slot_digit_d  = slot_digit_q;
    slot_blank_d  = slot_blank_q;
    slot_err_d    = slot_err_q;
    digit_array_d = digit_array_q;
    blank_mask_d  = blank_mask_q;
    number_d      = number_q;
    dec_error_d   = dec_error_q;
    frame_valid_d = frame_go;
    stalled_d     = stalled_q;
    to_cnt_d      = to_cnt_q;

    if (frame_go) begin
      digit_array_d = slot_digit_q;
      blank_mask_d  = slot_blank_q;
      dec_error_d   = frame_bad;
      number_d      = frame_bad ? 14'd0 : num_calc;
      seen_d        = '0;
      slot_err_d    = '0;
    end

    if (capture) begin
      to_cnt_d  = '0;
      stalled_d = 1'b0;
    end else if (to_cnt_q == TO_MAX) begin
      stalled_d = 1'b1;
      seen_d    = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    if (capture) begin
      slot_digit_d[cap_idx] = dec[3:0];
      slot_blank_d[cap_idx] = dec[4];
      slot_err_d[cap_idx]   = dec[5];
      seen_d[cap_idx]       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q        <= SNAP_IDLE;
      prev_q        <= SNAP_IDLE;
      settle_cnt_q  <= '0;
      dwell_done_q  <= 1'b0;
      to_cnt_q      <= '0;
      cap_last_q    <= 1'b0;
      seen_q        <= '0;
      slot_digit_q  <= '0;
      slot_blank_q  <= '0;
      slot_err_q    <= '0;
      digit_array_q <= '0;
      blank_mask_q  <= '0;
      number_q      <= '0;
      frame_valid_q <= 1'b0;
      dec_error_q   <= 1'b0;
      an_error_q    <= 1'b0;
      stalled_q     <= 1'b0;
    end else begin
      snap_q        <= snap_d;
      prev_q        <= prev_d;
      settle_cnt_q  <= settle_cnt_d;
      dwell_done_q  <= dwell_done_d;
      to_cnt_q      <= to_cnt_d;
      cap_last_q    <= cap_last_d;
      seen_q        <= seen_d;
      slot_digit_q  <= slot_digit_d;
      slot_blank_q  <= slot_blank_d;
      slot_err_q    <= slot_err_d;
      digit_array_q <= digit_array_d;
      blank_mask_q  <= blank_mask_d;
      number_q      <= number_d;
      frame_valid_q <= frame_valid_d;
      dec_error_q   <= dec_error_d;
      an_error_q    <= an_error_d;
      stalled_q     <= stalled_d;
    end
  end

  assign digit_array = digit_array_q;
  assign blank_mask  = blank_mask_q;
  assign number      = number_q;
  assign frame_valid = frame_valid_q;
  assign dec_error   = dec_error_q;
  assign an_error    = an_error_q;
  assign stalled     = stalled_q;
endmodule
